// File: rtl/tm1638_panel_pkg.sv
// Shared types and the hex font for the TM1638 key panel.
// Segment bytes are a..g in bits 7..1, with the dot in bit 0.
package tm1638_panel_pkg;

    typedef enum logic {
        LED_DIRECT = 1'b0,
        LED_TOGGLE = 1'b1
    } led_mode_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hFC;
            4'h1:    seg = 8'h60;
            4'h2:    seg = 8'hDA;
            4'h3:    seg = 8'hF2;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'hB6;
            4'h6:    seg = 8'hBE;
            4'h7:    seg = 8'hE0;
            4'h8:    seg = 8'hFE;
            4'h9:    seg = 8'hF6;
            4'hA:    seg = 8'hEE;
            4'hB:    seg = 8'h3E;
            4'hC:    seg = 8'h9C;
            4'hD:    seg = 8'h7A;
            4'hE:    seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchroniser, stability counter, debounced level and
// a press pulse issued on the same edge the level is accepted as high.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic stable,
    output logic pressed
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          stable_reg;
    logic          pressed_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            stable_reg  <= 1'b0;
            pressed_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], key};
            pressed_reg <= 1'b0;
            if (sync_reg[1] != stable_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg  <= sync_reg[1];
                    cnt_reg     <= '0;
                    // Only a 0->1 acceptance is a press; releases are silent.
                    pressed_reg <= sync_reg[1];
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign stable  = stable_reg;
    assign pressed = pressed_reg;

endmodule

// File: rtl/tm1638_key_panel.sv
// TM1638 front-panel controller: debounced keys, press counter, last key,
// LED drive and a multiplexed hex display of last key and count.
module tm1638_key_panel
    import tm1638_panel_pkg::*;
#(
    parameter int N_KEYS          = 8,
    parameter int N_DIGITS        = 8,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int SCAN_CYCLES     = 1024,
    parameter int LED_MODE        = 0,
    parameter int BLANK_ZEROS     = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [N_KEYS-1:0]         key,
    output logic [N_KEYS-1:0]         key_pressed,
    output logic [N_KEYS-1:0]         led,
    output logic [4*(N_DIGITS-2)-1:0] press_count,
    output logic [7:0]                last_key,
    output logic [7:0]                abcdefgh,
    output logic [N_DIGITS-1:0]       digit
);

    localparam int        W_CNT = 4 * (N_DIGITS - 2);
    localparam int        SW    = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int        DW    = $clog2(N_DIGITS);
    localparam led_mode_t MODE  = (LED_MODE != 0) ? LED_TOGGLE : LED_DIRECT;

    logic [N_KEYS-1:0] stable;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock  (clock),
                .reset  (reset),
                .key    (key[gi]),
                .stable (stable[gi]),
                .pressed(key_pressed[gi])
            );
        end
    endgenerate

    logic [W_CNT-1:0] pop_sum;
    logic [7:0]       high_idx;

    always_comb begin
        pop_sum  = '0;
        high_idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (key_pressed[i]) begin
                pop_sum  = pop_sum + W_CNT'(1);
                high_idx = 8'(i);
            end
        end
    end

    logic [W_CNT-1:0]  count_reg;
    logic [7:0]        last_reg;
    logic [N_KEYS-1:0] toggle_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg  <= '0;
            last_reg   <= '0;
            toggle_reg <= '0;
        end else if (clear) begin
            // Clear wins over any press arriving in the same cycle.
            count_reg  <= '0;
            last_reg   <= '0;
            toggle_reg <= '0;
        end else begin
            count_reg  <= count_reg + pop_sum;
            toggle_reg <= toggle_reg ^ key_pressed;
            if (|key_pressed) begin
                last_reg <= high_idx;
            end
        end
    end

    assign press_count = count_reg;
    assign last_key    = last_reg;
    assign led         = (MODE == LED_TOGGLE) ? toggle_reg : stable;

    // Segment pattern for every digit position, rebuilt combinationally.
    logic [N_DIGITS-1:0][7:0] seg_table;

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_dig
            if (gi < N_DIGITS - 2) begin : g_count
                logic blank;
                assign blank = (BLANK_ZEROS != 0) && (gi != 0) &&
                               !(|count_reg[W_CNT-1:4*gi]);
                assign seg_table[gi] = blank ? SEG_BLANK
                                             : hex_to_seg(count_reg[4*gi +: 4]);
            end else if (gi == N_DIGITS - 2) begin : g_last_lo
                assign seg_table[gi] = hex_to_seg(last_reg[3:0]) | 8'h01;
            end else begin : g_last_hi
                assign seg_table[gi] = hex_to_seg(last_reg[7:4]);
            end
        end
    endgenerate

    logic [SW-1:0]       scan_cnt_reg;
    logic [DW-1:0]       scan_idx_reg;
    logic [N_DIGITS-1:0] digit_reg;
    logic [7:0]          seg_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= '0;
            digit_reg    <= '0;
            seg_reg      <= '0;
        end else begin
            if (scan_cnt_reg == SW'(SCAN_CYCLES - 1)) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == DW'(N_DIGITS - 1)) ? '0
                                                                    : scan_idx_reg + DW'(1);
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SW'(1);
            end
            // Enable and segments are registered together so they switch on the same edge.
            digit_reg <= N_DIGITS'(1) << scan_idx_reg;
            seg_reg   <= seg_table[scan_idx_reg];
        end
    end

    assign digit    = digit_reg;
    assign abcdefgh = seg_reg;

endmodule

// File: doc/tm1638_key_panel.md
# tm1638_key_panel

Parametrised TM1638 front-panel controller. It sits between the board wrapper's logical `key`/`led`/`abcdefgh`/`digit` signals and user logic. Each key is synchronised and debounced, then turned into one-cycle press pulses. LEDs are driven in direct or toggle mode. The block keeps a press counter and a last-key register and shows both in hex on its own multiplexed 7-segment scanner.

## Interface
Parameters:
- `N_KEYS`, 8: number of keys and LEDs, 1..16.
- `N_DIGITS`, 8: number of 7-segment digits, 3..8.
- `DEBOUNCE_CYCLES`, 65536: stable cycles required to accept a key change, ≥2.
- `SCAN_CYCLES`, 1024: cycles each digit is held, ≥2.
- `LED_MODE`, 0: 0 = direct (LED follows debounced key); 1 = toggle (each press flips that LED).
- `BLANK_ZEROS`, 1: 1 = blank leading zeros of the count field.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `clear` in 1: synchronous clear of count, last key and toggle state.
- `key` in N_KEYS: raw key levels, active-high, asynchronous.
- `key_pressed` out N_KEYS: one-cycle press pulses.
- `led` out N_KEYS: LED drive, active-high.
- `press_count` out W_CNT = 4*(N_DIGITS-2): total presses, wraps.
- `last_key` out 8: index of the most recent key pressed.
- `abcdefgh` out 8: segments, active-high, a = bit 7, h (dot) = bit 0.
- `digit` out N_DIGITS: one-hot digit enable, active-high.

## Operation
- **Reset values.** All outputs are 0. All internal state is 0: sync flops, debounce counters, stable levels, scan index, scan counter.
- **Synchroniser.** Each key passes through 2 flops.
- **Debounce, per key.**
  - If the synced level differs from the stable level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synced value and the counter clears.
  - If the levels match, the counter clears.
- **Press detection.** `key_pressed[i]` is a registered stable 0→1 edge. There is no pulse on release.
- **Press count.** Adds the popcount of `key_pressed` each cycle, modulo 2^W_CNT.
- **Last key.** Takes the highest index set in `key_pressed`; unchanged when no pulse.
- **LEDs.** Mode 0: `led` = stable levels. Mode 1: `led[i]` toggles on `key_pressed[i]`.
- **Clear.** Count, last key and toggle-LED state go to 0. Clear beats any same-cycle press, so those presses are discarded. Debounce state is untouched, and mode-0 `led` still follows stable levels.
- **Display value.**
  - Digits N_DIGITS-1..N_DIGITS-2 show `last_key` in hex.
  - The lower digits show `press_count`.
  - With BLANK_ZEROS=1, a count digit that is 0 and above the highest nonzero count digit shows segments 0. Digit 0 is never blanked.
  - Font is 0-F hex; the dot is lit only on digit N_DIGITS-2, as a separator.
- **Scanner.**
  - The scan counter runs 0..SCAN_CYCLES-1.
  - On wrap, the scan index advances modulo N_DIGITS.
  - `digit` and `abcdefgh` are registered from the scan index and the current value. Both change in the same cycle, so there is no ghosting.

## Timing
- A raw key edge held steady produces the stable change and the `key_pressed` pulse 2 + DEBOUNCE_CYCLES cycles later.
- A bounce shorter than DEBOUNCE_CYCLES produces no change.
- `press_count`, `last_key` and toggle `led` update 1 cycle after the pulse. Direct `led` updates in the same cycle as the pulse.
- Display outputs lag the scan index and the value by 1 cycle. Each digit is active for exactly SCAN_CYCLES cycles.
- `digit` becomes 1 in the first cycle after reset deasserts.
- Reset mid-debounce or mid-scan returns everything to the reset values immediately, since reset is asynchronous.

## Structure
- Package `tm1638_panel_pkg` holds:
  - `led_mode_t` enum (`LED_DIRECT`, `LED_TOGGLE`);
  - function `hex_to_seg(logic [3:0]) → logic [7:0]`;
  - constant `SEG_BLANK`.
- Sub-module `key_debouncer`: one key covering synchroniser, counter, stable level and press pulse, instantiated N_KEYS times via generate.
- Top level holds the counter, last key, LEDs, blanking and scanner.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SCAN_CYCLES=4, N_KEYS=8, N_DIGITS=8, unless stated.
- **Clean press.** Raise `key[3]` and hold → `key_pressed` = 8'h08 exactly 6 cycles later, for 1 cycle. Next cycle: `press_count` = 1, `last_key` = 3.
- **Bounce.** Toggle `key[0]` with a 3-cycle period for 20 cycles, then drop it → no pulse, count stays 0. Then hold high → one pulse.
- **Simultaneous presses.** `key[1]` and `key[6]` rise together → `key_pressed` = 8'h42, count += 2, `last_key` = 6.
- **Toggle mode and clear.** With LED_MODE=1: press `key[2]` twice → `led[2]` reads 1, then 0. Assert `clear` in the same cycle as a pulse → count 0, the pulse is not counted, `led` = 0.
- **Wrap.** Force `press_count` to 24'hFFFFFF, press once → 0.
- **Scan and blanking.** Count 0x25 → `digit` steps 01, 02, … 80 every 4 cycles.
  - Digits 0 and 1 show "5" and "2".
  - Digits 2-5 show `abcdefgh` = 0.
  - Digit 6 shows the last-key low nibble with its dot lit (bit 0 = 1).
  - Reset mid-scan → `digit` = 0, then 01 one cycle after release.
